// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin selection among four register-file write
// sources, driving the shared 4:1 mux select and a one-entry write register.
module wb_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_v,
  input  logic [ADDR_W-1:0] req_rd0,
  input  logic [ADDR_W-1:0] req_rd1,
  input  logic [ADDR_W-1:0] req_rd2,
  input  logic [ADDR_W-1:0] req_rd3,
  output logic [3:0]        req_rdy,
  output logic [1:0]        f0,
  input  logic [DATA_W-1:0] rd_v,
  input  logic              wb_stall,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  logic [1:0]        ptr;
  logic [1:0]        winner;
  logic [1:0]        idx;
  logic              found;
  logic              any_req;
  logic              accept_ok;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;

  // Scan from ptr upward (mod 4); the first requesting index wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_v[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    any_req   = |req_v;
    accept_ok = ~(wb_we & wb_stall);
    f0        = '0;
    req_rdy   = '0;
    if (!rst) begin
      f0 = any_req ? winner : ptr;
      if (any_req && accept_ok) req_rdy = 4'b0001 << winner;
    end
    xfer = |(req_v & req_rdy);
  end

  always_comb begin
    unique case (winner)
      2'd0:    win_addr = req_rd0;
      2'd1:    win_addr = req_rd1;
      2'd2:    win_addr = req_rd2;
      default: win_addr = req_rd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (xfer) begin
      ptr     <= winner + 2'd1;
      wb_we   <= 1'b1;
      wb_addr <= win_addr;
      wb_data <= rd_v;
    end else if (!wb_stall) begin
      wb_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: reference model of pointer/write register plus a
// queue of expected write entries checked when they appear on wb_*.
module tb_wb_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_v;
  logic [ADDR_W-1:0] rd [4];
  logic [DATA_W-1:0] src_data [4];
  logic [3:0]        req_rdy;
  logic [1:0]        f0;
  logic [DATA_W-1:0] rd_v;
  logic              wb_stall;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Write-back mux in front of the arbiter.
  assign rd_v = src_data[f0];

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_v(req_v),
    .req_rd0(rd[0]), .req_rd1(rd[1]), .req_rd2(rd[2]), .req_rd3(rd[3]),
    .req_rdy(req_rdy), .f0(f0), .rd_v(rd_v), .wb_stall(wb_stall),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [1:0]              m_ptr  = '0;
  logic                    m_we   = 1'b0;
  logic [ADDR_W-1:0]       m_addr = '0;
  logic [DATA_W-1:0]       m_data = '0;
  logic [ADDR_W+DATA_W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] rv, input logic [1:0] p);
    logic [1:0] w;
    w = p;
    for (int k = 3; k >= 0; k--)
      if (rv[2'(p + 2'(k))]) w = 2'(p + 2'(k));
    return w;
  endfunction

  task automatic cycle(input logic r, input logic [3:0] rv, input logic st);
    logic [1:0]               w;
    logic                     any_r;
    logic                     xfer;
    logic [3:0]               rdy_e;
    logic [1:0]               f0_e;
    logic [ADDR_W+DATA_W-1:0] ent;
    rst = r; req_v = rv; wb_stall = st;
    #1;
    w     = pick(rv, m_ptr);
    any_r = |rv;
    xfer  = !r && any_r && !(m_we && st);
    f0_e  = r ? 2'd0 : (any_r ? w : m_ptr);
    rdy_e = xfer ? (4'b0001 << w) : 4'b0000;
    check("f0", 32'(f0), 32'(f0_e));
    check("req_rdy", 32'(req_rdy), 32'(rdy_e));
    ent = {rd[w], src_data[w]};
    @(posedge clk);
    if (r) begin
      m_ptr = '0; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (xfer) begin
      m_ptr = w + 2'd1; m_we = 1'b1;
      {m_addr, m_data} = ent;
      sb_q.push_back(ent);
    end else if (!st) begin
      m_we = 1'b0;
    end
    #1;
    check("wb_we", 32'(wb_we), 32'(m_we));
    if (xfer && sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      check("wb_addr_new", 32'(wb_addr), 32'(ent[ADDR_W+DATA_W-1:DATA_W]));
      check("wb_data_new", 32'(wb_data), 32'(ent[DATA_W-1:0]));
    end else begin
      check("wb_addr", 32'(wb_addr), 32'(m_addr));
      check("wb_data", 32'(wb_data), 32'(m_data));
    end
  endtask

  initial begin
    rst = 1'b1; req_v = '0; wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd[i] = 3'(i + 4);
      src_data[i] = 16'(16'h1000 * (i + 1) + i);
    end
    #2;

    // Reset with all sources requesting, then idle.
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Single source 1.
    rd[1] = 3'd5; src_data[1] = 16'hBEEF;
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Round robin from ptr 0, then 1001 after a grant to 0.
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b1001, 1'b0);

    // Backpressure holding a loaded entry.
    rd[2] = 3'd2; src_data[2] = 16'h1234;
    cycle(1'b0, 4'b0100, 1'b0);
    rd[2] = 3'd6; src_data[2] = 16'h5678;
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Stall while empty: one accept, then held.
    cycle(1'b0, 4'b0000, 1'b0);
    src_data[0] = 16'h00AA;
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0001, 1'b1);

    // Reset mid-stall, then first grant with 1100.
    cycle(1'b1, 4'b0001, 1'b1);
    cycle(1'b0, 4'b1100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 4; j++) begin
        rd[j] = 3'($urandom_range(0, 7));
        src_data[j] = 16'($urandom);
      end
      cycle(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and pipeline register for the 16-bit CPU register-file write port. Four sources share the 16-bit 4:1 write-back mux: index 0 = s, 1 = D, 2 = P, 3 = result. The block picks one requester per cycle round-robin and drives the mux select `f0`. It captures the mux output `rd_v` and destination address into a one-entry write register, and holds that register under `wb_stall` backpressure from the register file.

## Interface
Parameters:
- ADDR_W, 3, register-file address width
- DATA_W, 16, write-back data width; must equal the mux width

Ports:
- clk  in  1  rising-edge clock, sole clock of the block
- rst  in  1  synchronous, active-high reset
- req_v  in  4  per-source write request; bit i = mux input i
- req_rd0..req_rd3  in  ADDR_W each  destination register of source i
- req_rdy  out  4  per-source accept; transfer occurs when req_v[i] & req_rdy[i]
- f0  out  2  select to the write-back mux (combinational)
- rd_v  in  DATA_W  write-back mux output (combinational return path)
- wb_stall  in  1  register file cannot consume a write this cycle
- wb_we  out  1  write-register valid / register-file write enable (registered)
- wb_addr  out  ADDR_W  write-register address (registered)
- wb_data  out  DATA_W  write-register data (registered)

## Operation
- State:
  - round-robin pointer ptr[1:0], the highest-priority index this cycle
  - write register {wb_we, wb_addr, wb_data}
- accept_ok = ~(wb_we & wb_stall). A new write may load only when the register is empty or is draining this cycle.
- Winner: the first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req_v[i] = 1.
  - f0 = winner when any req_v is set; otherwise f0 = ptr.
- req_rdy is one-hot at the winner when accept_ok = 1 and any req_v is set; otherwise 0000.
  - No req_rdy bit is ever set for a source with req_v = 0.
- On a transfer (any req_v & req_rdy):
  - wb_we <= 1
  - wb_addr <= req_rd{winner}
  - wb_data <= rd_v
  - ptr <= winner + 1 (mod 4; 3 wraps to 0)
- No transfer and wb_stall = 0: wb_we <= 0. wb_addr and wb_data hold their values; ptr holds.
- No transfer and wb_stall = 1: the write register holds unchanged; ptr holds.
- Register file consumes the write on any cycle where wb_we = 1 and wb_stall = 0.
- Simultaneous drain and accept (wb_we = 1, wb_stall = 0, request present): the old entry is written this edge and the new entry loads. There is no bubble.
- wb_stall while wb_we = 0: accept_ok = 1. One write loads and is then held.
- A requester must hold req_v and keep its data stable on the mux input until it sees req_rdy. It may drop req_v only after the handshake.
- Same destination from two sources: no hazard logic. Writes commit in grant order.

## Timing
- Reset (rst high at a clock edge): wb_we = 0, wb_addr = 0, wb_data = 0, ptr = 0.
  - During rst, req_rdy = 0000 and f0 = 00.
  - Reset mid-stall discards the held write.
- f0 and req_rdy are combinational from req_v, ptr, wb_we and wb_stall. There is no combinational path from rd_v to any output.
- Latency: accept at edge N puts the write on wb_* in cycle N+1. It commits at the first edge with wb_stall = 0.
- Throughput: one write per cycle with wb_stall low.
- Fairness: a continuously asserting source is granted within 4 accepting cycles.

## Test plan
- Reset, then idle:
  - hold rst 2 cycles with req_v = 1111 -> req_rdy = 0000, wb_we = 0, wb_addr = 0, wb_data = 0.
  - After release with req_v = 0000 -> f0 = 00, wb_we stays 0.
- Single source:
  - req_v = 0010, req_rd1 = 5, rd_v = 16'hBEEF -> req_rdy = 0010 and f0 = 01 the same cycle.
  - Next cycle -> wb_we = 1, wb_addr = 5, wb_data = BEEF, ptr = 2.
- Round-robin:
  - req_v = 1111 held for 8 cycles with wb_stall = 0 -> grant order 0,1,2,3,0,1,2,3, wb_we = 1 continuously.
  - req_v = 1001 after a grant to 0 -> next grant goes to 3.
- Backpressure:
  - load addr 2 / data 1234, then wb_stall = 1 for 3 cycles with req_v = 0100 -> req_rdy = 0000, and wb_* holds 2/1234 for all 3 cycles.
  - Stall drops -> the same cycle grants source 2; the next cycle shows the new entry.
- Stall on empty:
  - wb_we = 0, wb_stall = 1, req_v = 0001, rd_v = 0x00AA -> one accept, then wb_we = 1 held with data 00AA. No further req_rdy until the stall releases.
- Reset mid-operation:
  - rst asserted while wb_we = 1 and wb_stall = 1 -> next cycle wb_we = 0, ptr = 0.
  - First post-reset grant with req_v = 1100 goes to source 2.
